// File: rtl/bin_morph_pkg.sv
// Shared constants and helpers for the 3x3 binary morphology stage.
package bin_morph_pkg;
  localparam logic MODE_DILATE   = 1'b0;
  localparam logic MODE_ERODE    = 1'b1;
  localparam int   MORPH_LATENCY = 3;

  // Off-image taps must be neutral for the reduction: 0 for OR, 1 for AND.
  function automatic logic pad_bit(input logic mode);
    return (mode == MODE_ERODE);
  endfunction
endpackage

// File: rtl/bin_linebuf_2row.sv
// Two 1-bit line rows (A = r-1 in bit 0, B = r-2 in bit 1) packed into one RAM word.
// Synchronous read-before-write: the new bit enters A while the old A moves down to B.
module bin_linebuf_2row #(
  parameter int DEPTH = 640,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic          wr_bit,
  output logic          tap_a,
  output logic          tap_b
);
  logic [1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      {tap_b, tap_a} <= mem[addr];
      mem[addr]      <= {mem[addr][0], wr_bit};
    end
  end
endmodule

// File: rtl/bin_morph_3x3.sv
// 3x3 binary dilation/erosion on a streamed 1-bit edge map, fixed 3-cycle latency.
// No backpressure: sync strobes shift every cycle, pixel pipeline advances only on valid.
module bin_morph_3x3
  import bin_morph_pkg::*;
#(
  parameter int IMG_WIDTH = 640,
  parameter int COL_W     = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic morph_en,
  input  logic morph_mode,
  input  logic pre_frame_vsync,
  input  logic pre_frame_hsync,
  input  logic pre_frame_valid,
  input  logic pre_img_bit,
  output logic post_frame_vsync,
  output logic post_frame_hsync,
  output logic post_frame_valid,
  output logic post_img_bit
);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_WIDTH - 1);

  logic [COL_W-1:0]         col;
  logic [1:0]               row;
  logic                     vsync_q, hsync_q, vs_rise, hs_fall;
  logic [MORPH_LATENCY-1:0] vs_pipe, hs_pipe, vld_pipe;
  logic                     tap_a, tap_b;
  logic                     s1_bit, s1_pad_b, s1_pad_a, s1_col_lt1, s1_col_lt2;
  logic [2:0]               win_t, win_m, win_b, padr_t, padr_m;
  logic                     s2_col_lt1, s2_col_lt2;
  logic [2:0]               col_pad, mask_t, mask_m, eff_t, eff_m, eff_b;
  logic                     pad, and9, or9, morph_res, out_sel;

  assign vs_rise = pre_frame_vsync & ~vsync_q;
  assign hs_fall = hsync_q & ~pre_frame_hsync;

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q  <= 1'b0;
      hsync_q  <= 1'b0;
      vs_pipe  <= '0;
      hs_pipe  <= '0;
      vld_pipe <= '0;
      col      <= '0;
      row      <= '0;
    end else begin
      vsync_q  <= pre_frame_vsync;
      hsync_q  <= pre_frame_hsync;
      vs_pipe  <= {vs_pipe[MORPH_LATENCY-2:0], pre_frame_vsync};
      hs_pipe  <= {hs_pipe[MORPH_LATENCY-2:0], pre_frame_hsync};
      vld_pipe <= {vld_pipe[MORPH_LATENCY-2:0], pre_frame_valid};
      // A pixel coinciding with the hsync fall has already used col for its RAM access.
      if (hs_fall)
        col <= '0;
      else if (pre_frame_valid && col != COL_MAX)
        col <= col + 1'b1;
      if (vs_rise)
        row <= '0;
      else if (hs_fall && row != 2'd2)
        row <= row + 1'b1;
    end
  end

  bin_linebuf_2row #(
    .DEPTH (IMG_WIDTH),
    .AW    (COL_W)
  ) u_linebuf (
    .clk    (clk),
    .we     (pre_frame_valid),
    .addr   (col),
    .wr_bit (pre_img_bit),
    .tap_a  (tap_a),
    .tap_b  (tap_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_bit     <= 1'b0;
      s1_pad_b   <= 1'b0;
      s1_pad_a   <= 1'b0;
      s1_col_lt1 <= 1'b0;
      s1_col_lt2 <= 1'b0;
    end else if (pre_frame_valid) begin
      s1_bit     <= pre_img_bit;
      s1_pad_b   <= (row < 2'd2);
      s1_pad_a   <= (row < 2'd1);
      s1_col_lt1 <= (col < COL_W'(1));
      s1_col_lt2 <= (col < COL_W'(2));
    end
  end

  // Bit 0 is the newest column (c), bit 2 the oldest (c-2).
  always_ff @(posedge clk) begin
    if (rst) begin
      win_t      <= '0;
      win_m      <= '0;
      win_b      <= '0;
      padr_t     <= '0;
      padr_m     <= '0;
      s2_col_lt1 <= 1'b0;
      s2_col_lt2 <= 1'b0;
    end else if (vld_pipe[0]) begin
      win_t      <= {win_t[1:0], tap_b};
      win_m      <= {win_m[1:0], tap_a};
      win_b      <= {win_b[1:0], s1_bit};
      padr_t     <= {padr_t[1:0], s1_pad_b};
      padr_m     <= {padr_m[1:0], s1_pad_a};
      s2_col_lt1 <= s1_col_lt1;
      s2_col_lt2 <= s1_col_lt2;
    end
  end

  // Row padding is kept per column and resolved here so the pad value follows morph_mode at this stage.
  assign pad       = pad_bit(morph_mode);
  assign col_pad   = {s2_col_lt2, s2_col_lt1, 1'b0};
  assign mask_t    = padr_t | col_pad;
  assign mask_m    = padr_m | col_pad;
  assign eff_t     = (win_t & ~mask_t)  | ({3{pad}} & mask_t);
  assign eff_m     = (win_m & ~mask_m)  | ({3{pad}} & mask_m);
  assign eff_b     = (win_b & ~col_pad) | ({3{pad}} & col_pad);
  assign and9      = &{eff_t, eff_m, eff_b};
  assign or9       = |{eff_t, eff_m, eff_b};
  assign morph_res = (morph_mode == MODE_DILATE) ? or9 : and9;
  assign out_sel   = morph_en ? morph_res : win_b[0];

  always_ff @(posedge clk) begin
    if (rst)
      post_img_bit <= 1'b0;
    else
      post_img_bit <= vld_pipe[1] & out_sel;
  end

  assign post_frame_vsync = vs_pipe[MORPH_LATENCY-1];
  assign post_frame_hsync = hs_pipe[MORPH_LATENCY-1];
  assign post_frame_valid = vld_pipe[MORPH_LATENCY-1];
endmodule

// File: tb/tb_bin_morph_3x3.sv
// Self-checking bench for bin_morph_3x3: 8x6 frames checked against a neighbourhood OR/AND model.
module tb_bin_morph_3x3;
  localparam int W = 8;
  localparam int H = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic morph_en = 1'b0, morph_mode = 1'b0;
  logic pre_frame_vsync = 1'b0, pre_frame_hsync = 1'b0, pre_frame_valid = 1'b0, pre_img_bit = 1'b0;
  logic post_frame_vsync, post_frame_hsync, post_frame_valid, post_img_bit;

  int vec  = 0;
  int errs = 0;
  logic [3:0] in_log[$];
  logic [3:0] out_log[$];
  logic       img [H][W];
  logic       got[$];

  bin_morph_3x3 #(.IMG_WIDTH(W), .COL_W(3)) dut (
    .clk              (clk),
    .rst              (rst),
    .morph_en         (morph_en),
    .morph_mode       (morph_mode),
    .pre_frame_vsync  (pre_frame_vsync),
    .pre_frame_hsync  (pre_frame_hsync),
    .pre_frame_valid  (pre_frame_valid),
    .pre_img_bit      (pre_img_bit),
    .post_frame_vsync (post_frame_vsync),
    .post_frame_hsync (post_frame_hsync),
    .post_frame_valid (post_frame_valid),
    .post_img_bit     (post_img_bit)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    in_log.push_back({pre_frame_vsync, pre_frame_hsync, pre_frame_valid, pre_img_bit});
    out_log.push_back({post_frame_vsync, post_frame_hsync, post_frame_valid, post_img_bit});
  end

  // Reference: output at (r,c) reduces the 3x3 input neighbourhood rows r-2..r, cols c-2..c.
  function automatic logic model(input logic en, input logic mode, input int r, input int c);
    logic acc, p;
    if (!en) return img[r][c];
    acc = mode;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++) begin
        p   = (r - dr < 0 || c - dc < 0) ? mode : img[r-dr][c-dc];
        acc = mode ? (acc & p) : (acc | p);
      end
    return acc;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    pre_frame_valid = 1'b0;
    pre_img_bit     = 1'b0;
    repeat (n) tick();
  endtask

  task automatic drive_line(input int r, input int gap_pct);
    pre_frame_hsync = 1'b1;
    for (int c = 0; c < W; c++) begin
      for (int g = 0; g < 3 && int'($urandom_range(99)) < gap_pct; g++) begin
        pre_frame_valid = 1'b0;
        pre_img_bit     = 1'($urandom);
        tick();
      end
      pre_frame_valid = 1'b1;
      pre_img_bit     = img[r][c];
      tick();
    end
    pre_frame_valid = 1'b0;
    pre_img_bit     = 1'b0;
    pre_frame_hsync = 1'b0;
    tick();
    tick();
  endtask

  task automatic drive_frame(input int gap_pct);
    pre_frame_vsync = 1'b1;
    idle(2);
    for (int r = 0; r < H; r++) drive_line(r, gap_pct);
    pre_frame_vsync = 1'b0;
    idle(4);
  endtask

  task automatic fill_random();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = 1'($urandom);
  endtask

  task automatic fill_const(input logic v);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = v;
  endtask

  task automatic grab(input int start);
    got.delete();
    for (int i = start; i < out_log.size(); i++)
      if (out_log[i][1] === 1'b1) got.push_back(out_log[i][0]);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      {morph_en, morph_mode, pre_frame_vsync, pre_frame_hsync, pre_frame_valid, pre_img_bit} = 6'($urandom);
      tick();
      vec++;
      if ({post_frame_vsync, post_frame_hsync, post_frame_valid, post_img_bit} !== 4'b0) begin
        errs++;
        $display("FAIL reset_cycle%0d: outputs %b, need 0000", i,
                 {post_frame_vsync, post_frame_hsync, post_frame_valid, post_img_bit});
      end
    end
    rst = 1'b0;
    tick();
    vec++;
    if ({post_frame_vsync, post_frame_hsync, post_frame_valid, post_img_bit} !== 4'b0) begin
      errs++;
      $display("FAIL reset_release: outputs %b, need 0000",
               {post_frame_vsync, post_frame_hsync, post_frame_valid, post_img_bit});
    end
    {morph_en, morph_mode, pre_frame_vsync, pre_frame_hsync} = 4'b0;
    idle(6);
  endtask

  task automatic test_dilation();
    int start, ones;
    logic exp;
    fill_const(1'b0);
    img[3][3] = 1'b1;
    morph_en = 1'b1; morph_mode = 1'b0;
    start = in_log.size();
    drive_frame(0);
    grab(start);
    vec++;
    if (got.size() !== W*H) begin
      errs++; $display("FAIL dil_count: %0d valid outputs, need %0d", got.size(), W*H);
    end
    ones = 0;
    for (int k = 0; k < got.size() && k < W*H; k++) begin
      exp = model(1'b1, 1'b0, k / W, k % W);
      vec++;
      if (got[k] !== exp) begin
        errs++; $display("FAIL dil_bit r%0d c%0d: got %b, need %b", k / W, k % W, got[k], exp);
      end
      if (got[k] === 1'b1) ones++;
    end
    vec++;
    if (ones != 9) begin
      errs++; $display("FAIL dil_ones: %0d ones, need 9", ones);
    end
  endtask

  task automatic test_erosion();
    int start, ones;
    logic exp;
    fill_const(1'b0);
    for (int r = 2; r <= 4; r++)
      for (int c = 2; c <= 4; c++) img[r][c] = 1'b1;
    morph_en = 1'b1; morph_mode = 1'b1;
    start = in_log.size();
    drive_frame(0);
    grab(start);
    ones = 0;
    for (int k = 0; k < got.size() && k < W*H; k++) begin
      exp = model(1'b1, 1'b1, k / W, k % W);
      vec++;
      if (got[k] !== exp) begin
        errs++; $display("FAIL ero_bit r%0d c%0d: got %b, need %b", k / W, k % W, got[k], exp);
      end
      if (got[k] === 1'b1) ones++;
    end
    vec++;
    if (ones != 1 || got.size() != W*H || got[4*W+4] !== 1'b1) begin
      errs++; $display("FAIL ero_single: %0d ones of %0d outputs, need 1 at (4,4)", ones, got.size());
    end
    fill_const(1'b1);
    start = in_log.size();
    drive_frame(0);
    grab(start);
    ones = 0;
    for (int k = 0; k < got.size(); k++) if (got[k] === 1'b1) ones++;
    vec++;
    if (ones != W*H || got.size() != W*H) begin
      errs++; $display("FAIL ero_all_ones: %0d ones of %0d outputs, need 48 of 48", ones, got.size());
    end
  endtask

  task automatic test_timing();
    int start;
    logic exp;
    fill_random();
    morph_en = 1'b1; morph_mode = 1'($urandom);
    start = in_log.size();
    drive_frame(35);
    for (int i = start; i + 3 < out_log.size(); i++) begin
      vec++;
      if (out_log[i+3][3:1] !== in_log[i][3:1]) begin
        errs++; $display("FAIL tim_strobe cyc%0d: got %b, need %b", i, out_log[i+3][3:1], in_log[i][3:1]);
      end
      if (in_log[i][1] === 1'b0) begin
        vec++;
        if (out_log[i+3][0] !== 1'b0) begin
          errs++; $display("FAIL tim_idle_bit cyc%0d: got %b, need 0", i, out_log[i+3][0]);
        end
      end
    end
    grab(start);
    vec++;
    if (got.size() !== W*H) begin
      errs++; $display("FAIL tim_count: %0d valid outputs, need %0d", got.size(), W*H);
    end
    for (int k = 0; k < got.size() && k < W*H; k++) begin
      exp = model(1'b1, morph_mode, k / W, k % W);
      vec++;
      if (got[k] !== exp) begin
        errs++; $display("FAIL tim_bit r%0d c%0d: got %b, need %b", k / W, k % W, got[k], exp);
      end
    end
  endtask

  task automatic test_bypass();
    int start;
    fill_random();
    morph_en = 1'b0; morph_mode = 1'($urandom);
    start = in_log.size();
    drive_frame(25);
    grab(start);
    vec++;
    if (got.size() !== W*H) begin
      errs++; $display("FAIL byp_count: %0d valid outputs, need %0d", got.size(), W*H);
    end
    for (int k = 0; k < got.size() && k < W*H; k++) begin
      vec++;
      if (got[k] !== img[k / W][k % W]) begin
        errs++; $display("FAIL byp_bit r%0d c%0d: got %b, need %b", k / W, k % W, got[k], img[k / W][k % W]);
      end
    end
  endtask

  task automatic test_midframe_reset();
    int start;
    logic exp;
    fill_random();
    morph_en = 1'b1; morph_mode = 1'b0;
    pre_frame_vsync = 1'b1;
    idle(2);
    for (int r = 0; r < 3; r++) drive_line(r, 10);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    for (int r = 3; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = 1'b0;
    start = in_log.size();
    for (int r = 3; r < H; r++) drive_line(r, 10);
    pre_frame_vsync = 1'b0;
    idle(4);
    grab(start);
    vec++;
    if (got.size() !== 3*W) begin
      errs++; $display("FAIL mrst_count: %0d valid outputs, need %0d", got.size(), 3*W);
    end
    for (int k = 0; k < got.size(); k++) begin
      vec++;
      if (got[k] !== 1'b0) begin
        errs++; $display("FAIL mrst_stale k%0d: got %b, need 0", k, got[k]);
      end
    end
    fill_random();
    start = in_log.size();
    drive_frame(10);
    grab(start);
    vec++;
    if (got.size() !== W*H) begin
      errs++; $display("FAIL mrst_fresh_count: %0d valid outputs, need %0d", got.size(), W*H);
    end
    for (int k = 0; k < got.size() && k < W*H; k++) begin
      exp = model(1'b1, 1'b0, k / W, k % W);
      vec++;
      if (got[k] !== exp) begin
        errs++; $display("FAIL mrst_fresh r%0d c%0d: got %b, need %b", k / W, k % W, got[k], exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_dilation();
    test_erosion();
    test_timing();
    test_bypass();
    test_midframe_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
